// File: rtl/sum5_pkg.sv
// sum5_pkg: shared slice width and controller state encoding
package sum5_pkg;
  localparam int SLICE_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sum5_state_t;
endpackage

// File: rtl/my_sum5.sv
// my_sum5: 5-bit combinational adder slice with carry in/out
module my_sum5 import sum5_pkg::*; (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
endmodule

// File: rtl/sum5_mw_seq.sv
// sum5_mw_seq: multi-word adder reusing one my_sum5 slice per clock, carry rippled through a register
// Define SUM5_OVF_EN to add the signed-overflow output ovf.
module sum5_mw_seq import sum5_pkg::*; #(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     ci,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                     co
`ifdef SUM5_OVF_EN
  ,
  output logic                     ovf
`endif
);
  localparam int W  = SLICE_W * WORDS;
  localparam int IW = $clog2(WORDS + 1);
  sum5_state_t        state;
  logic [IW-1:0]      idx;
  logic [W-1:0]       opa, opb, res, nres;
  logic               cr, sco, last;
  logic [SLICE_W-1:0] ss;
`ifdef SUM5_OVF_EN
  logic am, bm;
`endif
  my_sum5 u_slice (.a(opa[SLICE_W-1:0]), .b(opb[SLICE_W-1:0]), .ci(cr), .s(ss), .co(sco));
  // new slice enters at the MSB end so slice k settles at bits [5k+4:5k]
  assign nres  = W'({ss, res} >> SLICE_W);
  assign last  = idx == IW'(WORDS - 1);
  assign ready = state == IDLE;
  assign busy  = state == RUN;
  assign done  = state == DONE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cr    <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef SUM5_OVF_EN
      am    <= 1'b0;
      bm    <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (start) begin
          opa   <= a;
          opb   <= b;
          cr    <= ci;
          idx   <= '0;
          state <= RUN;
`ifdef SUM5_OVF_EN
          am    <= a[W-1];
          bm    <= b[W-1];
`endif
        end
        RUN: begin
          opa <= opa >> SLICE_W;
          opb <= opb >> SLICE_W;
          res <= nres;
          cr  <= sco;
          idx <= idx + IW'(1);
          // outputs load on the last slice so they are already valid while done is high
          if (last) begin
            state <= DONE;
            sum   <= nres;
            co    <= sco;
`ifdef SUM5_OVF_EN
            ovf   <= (am == bm) && (ss[SLICE_W-1] != am);
`endif
          end
        end
        default: state <= IDLE;
      endcase
endmodule
